// File: rtl/leaf_arb_pkg.sv
// Shared types and constants for the leaf output arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package leaf_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of each per-requester statistics counter
    localparam int STAT_W = 16;

    // Burst counter width; holds BURST_LEN-1 for BURST_LEN up to 255
    localparam int BURST_CNT_W = 8;

    // Increment an index modulo n
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Bundle of requester, leaf-side and statistics signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: ack_arb2user toward users, ack_interface2arb from the leaf.
interface leaf_out_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    localparam int TAG_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb;
    logic [NUM_REQ-1:0]              vld_user2arb;
    logic [NUM_REQ-1:0]              ack_arb2user;
    logic [PAYLOAD_BITS-1:0]         dout_arb2interface;
    logic [TAG_W-1:0]                tag_arb2interface;
    logic                            vld_arb2interface;
    logic                            ack_interface2arb;
    logic [TAG_W-1:0]                stat_sel;
    logic [15:0]                     stat_count;

    // Environment side: users plus the leaf interface
    modport master (
        output din_user2arb, vld_user2arb, ack_interface2arb, stat_sel,
        input  ack_arb2user, dout_arb2interface, tag_arb2interface,
               vld_arb2interface, stat_count
    );

    // Arbiter side
    modport slave (
        input  din_user2arb, vld_user2arb, ack_interface2arb, stat_sel,
        output ack_arb2user, dout_arb2interface, tag_arb2interface,
               vld_arb2interface, stat_count
    );
endinterface

// File: rtl/rr_pick.sv
// Wrap-around first-set search starting at ptr.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
    parameter int  N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan ptr, ptr+1, ... wrapping at N; the first set bit wins
    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req[W'(cand)]) begin
                any = 1'b1;
                idx = W'(cand);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ user streams onto one leaf port; ARB_STATS_EN adds per-requester word counters.
// Latency: 1 cycle from accepted user word to registered dout; one IDLE bubble between grants.
// Backpressure: granted user sees ack only when the output register is empty or draining this cycle.
module leaf_out_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  PAYLOAD_BITS = 32,
    parameter int  BURST_LEN    = 16,
    localparam int TAG_W        = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic [TAG_W-1:0]                tag_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb,
    input  logic [TAG_W-1:0]                stat_sel,
    output logic [STAT_W-1:0]               stat_count
);

    arb_state_t              state_q, state_d;
    logic [TAG_W-1:0]        grant_q, grant_d;
    logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BURST_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    vld_q, vld_d;
    logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
    logic [TAG_W-1:0]        tag_q, tag_d;

    logic [TAG_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    in_grant;
    logic                    out_free;
    logic                    grant_vld;
    logic                    accept;
    logic [TAG_W-1:0]        next_ptr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (vld_user2arb),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign in_grant  = (state_q == GRANT);
    assign out_free  = !vld_q || ack_interface2arb;
    assign grant_vld = vld_user2arb[grant_q];
    assign accept    = in_grant && out_free && grant_vld;
    assign next_ptr  = TAG_W'(wrap_inc(int'(grant_q), NUM_REQ));

    assign dout_arb2interface = dout_q;
    assign tag_arb2interface  = tag_q;
    assign vld_arb2interface  = vld_q;

    // Only the granted requester may see ready, and only when the output slot frees up
    always_comb begin
        ack_arb2user = '0;
        if (in_grant) ack_arb2user[grant_q] = out_free;
    end

    // Grant FSM: pick in IDLE, end the grant on an idle slot or a full burst
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (out_free) begin
                    if (!grant_vld || cnt_q == BURST_CNT_W'(BURST_LEN - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on accept, otherwise drain when the leaf takes the word
    always_comb begin
        vld_d  = vld_q;
        dout_d = dout_q;
        tag_d  = tag_q;
        if (accept) begin
            vld_d  = 1'b1;
            dout_d = din_user2arb[int'(grant_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
            tag_d  = grant_q;
        end else if (ack_interface2arb) begin
            vld_d = 1'b0;
        end
    end

    // State and output registers; reset discards any held word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
            tag_q    <= tag_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];
    logic [STAT_W-1:0] stat_d [NUM_REQ];

    // Saturating per-requester count of accepted words
    always_comb begin
        stat_d = stat_q;
        if (accept && stat_q[grant_q] != '1) stat_d[grant_q] = stat_q[grant_q] + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_count = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: single stream, rotation, stalls, early drop, reset, stats.
// Latency: n/a.
// Backpressure: leaf-side ack driven directly by the sequence.
module tb_leaf_out_arbiter;
    localparam int N  = 4;
    localparam int PB = 32;
    localparam int BL = 16;
    localparam int TW = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_out_arbiter_if #(.NUM_REQ(N), .PAYLOAD_BITS(PB)) ifc();

    leaf_out_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .BURST_LEN(BL)) dut (
        .clk                (clk),
        .reset              (reset),
        .din_user2arb       (ifc.din_user2arb),
        .vld_user2arb       (ifc.vld_user2arb),
        .ack_arb2user       (ifc.ack_arb2user),
        .dout_arb2interface (ifc.dout_arb2interface),
        .tag_arb2interface  (ifc.tag_arb2interface),
        .vld_arb2interface  (ifc.vld_arb2interface),
        .ack_interface2arb  (ifc.ack_interface2arb),
        .stat_sel           (ifc.stat_sel),
        .stat_count         (ifc.stat_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rem [N];
    logic [PB-1:0] dat [N];
    logic [TW+PB-1:0] out_q [$];
    int out_cyc [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ow(input int t, input logic [PB-1:0] d);
        return 64'({TW'(t), d});
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ifc.vld_user2arb[i] = (rem[i] != 0);
            ifc.din_user2arb[i*PB +: PB] = dat[i];
        end
    endtask

    // One clock: apply inputs, record handshakes mid-cycle, end at posedge+1
    task automatic cycle();
        drive();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (ifc.vld_user2arb[i] && ifc.ack_arb2user[i]) begin
                rem[i]--;
                dat[i]++;
            end
        end
        if (ifc.vld_arb2interface && ifc.ack_interface2arb) begin
            out_q.push_back({ifc.tag_arb2interface, ifc.dout_arb2interface});
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit quiet();
        bit q;
        q = !ifc.vld_arb2interface;
        for (int i = 0; i < N; i++) if (rem[i] != 0) q = 1'b0;
        return q;
    endfunction

    task automatic run_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            cycle();
            n++;
        end
        check(name, 64'(quiet()), 64'd1);
        cycle();
        cycle();
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        clear_out();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            dat[i] = '0;
        end
        ifc.ack_interface2arb = 1'b1;
        ifc.stat_sel = '0;
        drive();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_vld",  64'(ifc.vld_arb2interface), 64'd0);
        check("rst_dout", 64'(ifc.dout_arb2interface), 64'd0);
        check("rst_tag",  64'(ifc.tag_arb2interface), 64'd0);
        check("rst_ack",  64'(ifc.ack_arb2user), 64'd0);
        check("rst_stat", 64'(ifc.stat_count), 64'd0);
        reset = 1'b0;

        // Single requester 2, five words
        rem[2] = 5;
        dat[2] = 32'hA0;
        drive();
        #1;
        check("a_idle_ack", 64'(ifc.ack_arb2user), 64'h0);
        cycle();
        drive();
        #1;
        check("a_grant_ack", 64'(ifc.ack_arb2user), 64'h4);
        run_idle(30, "a_timeout");
        check("a_count", 64'(out_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < out_q.size()) check($sformatf("a_word%0d", k), 64'(out_q[k]), ow(2, 32'hA0 + k));
            if (k > 0 && k < out_q.size()) check($sformatf("a_gap%0d", k), 64'(out_cyc[k] - out_cyc[k-1]), 64'd1);
        end
        check("a_drained", 64'(ifc.vld_arb2interface), 64'd0);

        // Pointer left at 3: all four with one word each -> 3,0,1,2
        clear_out();
        for (int i = 0; i < N; i++) begin
            rem[i] = 1;
            dat[i] = 32'hB0 + i;
        end
        run_idle(40, "b_timeout");
        check("b_count", 64'(out_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            int t;
            t = (k + 3) % N;
            if (k < out_q.size()) check($sformatf("b_word%0d", k), 64'(out_q[k]), ow(t, 32'hB0 + t));
        end

        // All continuously valid: 16-word bursts in order 0,1,2,3,0 with one bubble
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = 100;
            dat[i] = PB'(i + 1) << 28;
        end
        for (int n = 0; n < 300 && out_q.size() < 80; n++) cycle();
        check("c_timeout", 64'(out_q.size() >= 80), 64'd1);
        for (int k = 0; k < 80 && k < out_q.size(); k++) begin
            int g;
            int s;
            g = (k / BL) % N;
            s = (k / (BL * N)) * BL + (k % BL);
            check($sformatf("c_word%0d", k), 64'(out_q[k]), ow(g, (PB'(g + 1) << 28) + PB'(s)));
            if (k > 0) check($sformatf("c_gap%0d", k), 64'(out_cyc[k] - out_cyc[k-1]), (k % BL == 0) ? 64'd2 : 64'd1);
        end
        for (int i = 0; i < N; i++) rem[i] = 0;
        run_idle(40, "c_drain");

        // Leaf stalls for three cycles while requester 0 holds a word
        do_reset();
        rem[0] = 6;
        dat[0] = 32'hC0;
        cycle();
        cycle();
        ifc.ack_interface2arb = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive();
            #1;
            check($sformatf("d_hold_vld%0d", s), 64'(ifc.vld_arb2interface), 64'd1);
            check($sformatf("d_hold_dout%0d", s), 64'(ifc.dout_arb2interface), 64'hC0);
            check($sformatf("d_hold_ack%0d", s), 64'(ifc.ack_arb2user), 64'h0);
            cycle();
        end
        ifc.ack_interface2arb = 1'b1;
        run_idle(40, "d_timeout");
        check("d_count", 64'(out_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < out_q.size(); k++)
            check($sformatf("d_word%0d", k), 64'(out_q[k]), ow(0, 32'hC0 + k));
        ifc.stat_sel = 0;
        #1;
`ifdef ARB_STATS_EN
        check("d_stat0", 64'(ifc.stat_count), 64'd6);
`else
        check("d_stat0", 64'(ifc.stat_count), 64'd0);
`endif
        ifc.stat_sel = 1;
        #1;
        check("d_stat1", 64'(ifc.stat_count), 64'd0);

        // Requester 1 stops after 3 words while 3 waits -> 3 next
        do_reset();
        rem[1] = 3;
        dat[1] = 32'h10;
        rem[3] = 4;
        dat[3] = 32'h30;
        run_idle(40, "e_timeout");
        check("e_count", 64'(out_q.size()), 64'd7);
        for (int k = 0; k < 7 && k < out_q.size(); k++) begin
            if (k < 3) check($sformatf("e_word%0d", k), 64'(out_q[k]), ow(1, 32'h10 + k));
            else       check($sformatf("e_word%0d", k), 64'(out_q[k]), ow(3, 32'h30 + k - 3));
        end

        // Reset mid-burst with a held word; restart from the lowest active index
        do_reset();
        rem[2] = 1;
        dat[2] = 32'hE0;
        run_idle(20, "f_setup");
        clear_out();
        rem[3] = 10;
        dat[3] = 32'hF30;
        rem[1] = 10;
        dat[1] = 32'hF10;
        cycle();
        cycle();
        check("f_pre_vld", 64'(ifc.vld_arb2interface), 64'd1);
        check("f_pre_tag", 64'(ifc.tag_arb2interface), 64'd3);
        reset = 1'b1;
        #1;
        check("f_rst_vld",  64'(ifc.vld_arb2interface), 64'd0);
        check("f_rst_dout", 64'(ifc.dout_arb2interface), 64'd0);
        check("f_rst_ack",  64'(ifc.ack_arb2user), 64'h0);
        cycle();
        reset = 1'b0;
        clear_out();
        for (int n = 0; n < 10 && out_q.size() < 1; n++) cycle();
        check("f_restart_seen", 64'(out_q.size() >= 1), 64'd1);
        if (out_q.size() >= 1) check("f_restart_word", 64'(out_q[0]), ow(1, 32'hF10));
        for (int i = 0; i < N; i++) rem[i] = 0;
        run_idle(40, "f_drain");

        // Statistics saturation on requester 1
`ifdef ARB_STATS_EN
        do_reset();
        rem[1] = 70000;
        dat[1] = '0;
        run_idle(80000, "g_timeout");
        clear_out();
        ifc.stat_sel = 1;
        #1;
        check("g_stat_sat", 64'(ifc.stat_count), 64'hFFFF);
`else
        ifc.stat_sel = 1;
        #1;
        check("g_stat_off", 64'(ifc.stat_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of user output streams sharing one leaf output port (2..8).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32: word width.
REQ-003 SHALL have parameter BURST_LEN, default 16: maximum words per grant before rotation (1..255).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port din_user2arb  in  NUM_REQ*PAYLOAD_BITS  requester data; slice i belongs to requester i.
REQ-007 SHALL have port vld_user2arb  in  NUM_REQ  per-requester valid.
REQ-008 SHALL have port ack_arb2user  out  NUM_REQ  per-requester ready (TREADY-style).
REQ-009 SHALL have port dout_arb2interface  out  PAYLOAD_BITS  registered word toward the leaf interface.
REQ-010 SHALL have port tag_arb2interface  out  $clog2(NUM_REQ)  source index of dout word.
REQ-011 SHALL have port vld_arb2interface  out  1  output word valid.
REQ-012 SHALL have port ack_interface2arb  in  1  leaf interface accepts the word.
REQ-013 SHALL have port stat_sel  in  $clog2(NUM_REQ)  statistics counter select.
REQ-014 SHALL have port stat_count  out  16  selected counter value.

Function
REQ-015 SHALL transfer on a channel only when valid and ack are both high on a rising edge.
REQ-016 SHALL have states IDLE and GRANT, with a grant index and a round-robin pointer rr_ptr.
REQ-017 In IDLE, SHALL select the first i with vld_user2arb[i]=1, searching from rr_ptr upward with wrap; it SHALL enter GRANT with grant=i on the next edge and assert no ack that cycle.
REQ-018 In GRANT, ack_arb2user[grant] SHALL equal (!vld_arb2interface | ack_interface2arb), and all other acks SHALL be 0.
REQ-019 SHALL register an accepted word into dout/tag/vld with 1-cycle latency, so one word per cycle is sustained with no bubble while ack_interface2arb stays high.
REQ-020 vld_arb2interface SHALL hold, and dout/tag SHALL remain stable, until ack_interface2arb; it SHALL clear after the handshake if no new word loads.
REQ-021 SHALL count words accepted in the current grant; on acceptance of word BURST_LEN it SHALL return to IDLE.
REQ-022 SHALL return to IDLE when the granted requester has vld low while its ack is high (idle slot).
REQ-023 On every GRANT-to-IDLE transition, SHALL set rr_ptr to (grant+1) mod NUM_REQ.
REQ-024 With vld low and ack high in the same cycle, SHALL not load a word, and SHALL end the grant.
REQ-025 SHALL keep the output register draining normally across the IDLE cycle.
REQ-026 Requesters not granted SHALL see ack low and SHALL keep their data untouched.

Reset
REQ-027 While reset=1, SHALL force state=IDLE, rr_ptr=0, grant=0, burst count=0, vld_arb2interface=0, dout=0, tag=0, all acks=0, and stat counters=0.
REQ-028 Reset asserted mid-burst SHALL discard the held output word; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-029 With ARB_STATS_EN defined, SHALL keep one 16-bit saturating counter per requester, incremented on each accepted word; stat_count SHALL return counter[stat_sel] combinationally.
REQ-030 Without ARB_STATS_EN, SHALL have no counters, and stat_count SHALL be constant 0; the ports SHALL still exist.

Structure
REQ-031 SHALL take the state encoding (IDLE/GRANT) and the stats width constant (16) from the shared package leaf_arb_pkg.
REQ-032 SHALL place the wrap-around first-set search in sub-module rr_pick (inputs req and ptr; outputs idx and any).

Verification
REQ-033 Only requester 2 has vld for 5 words 0xA0..0xA4 with downstream ack always high -> 1-cycle IDLE bubble, then 5 consecutive words with tag=2, then IDLE with rr_ptr=3.
REQ-034 All 4 requesters have continuous vld, BURST_LEN=16 -> grants in order 0,1,2,3,0, each exactly 16 words, with one bubble cycle between grants.
REQ-035 Requester 0 granted while ack_interface2arb is low for 3 cycles -> vld_arb2interface held with dout unchanged and ack_arb2user[0]=0, then resume with no word lost or duplicated.
REQ-036 Requester 1 drops vld after 3 of 16 words while requester 3 is pending -> grant ends, rr_ptr=2, and requester 3 is granted next.
REQ-037 Reset pulsed mid-burst with output valid -> vld_arb2interface=0 immediately (async), and the next grant goes to the lowest active index.
REQ-038 With ARB_STATS_EN, 70000 words pushed on requester 1 -> stat_sel=1 reads 0xFFFF (saturated); without the macro it reads 0.
